// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered N-way request arbiter, fixed priority (highest index
// wins) or downward round-robin, presenting a held valid/ready grant.
module prio_arb_rr #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          grant_ready,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_oh
);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_oh;
    logic [IW-1:0] r_ptr;

    logic          w_hs;
    logic          w_load;
    logic          w_any;
    logic [IW-1:0] w_base;
    logic [IW-1:0] w_fx_idx;
    logic [IW-1:0] w_rr_idx;
    logic [IW-1:0] w_win;
    logic [N-1:0]  w_oh;
    int            w_dist;
    int            w_best_dist;

    always_comb begin
        w_hs   = r_valid & grant_ready;
        w_load = ~r_valid | w_hs;
        w_any  = |req;
        if (w_hs) begin
            w_base = (r_idx == '0) ? IDX_LAST : r_idx - IW'(1);
        end else begin
            w_base = r_ptr;
        end
    end

    // Round-robin winner is the requester at the smallest downward distance
    // from the base, distance taken modulo N so the wrap is exact for any N.
    always_comb begin
        w_fx_idx    = '0;
        w_rr_idx    = '0;
        w_dist      = 0;
        w_best_dist = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                w_fx_idx = IW'(i);
            end
            w_dist = int'(w_base) - i;
            if (w_dist < 0) begin
                w_dist = w_dist + N;
            end
            if (req[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_rr_idx    = IW'(i);
            end
        end
        w_win = mode ? w_rr_idx : w_fx_idx;
        w_oh  = '0;
        for (int i = 0; i < N; i++) begin
            w_oh[i] = (w_win == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_oh    <= '0;
            r_ptr   <= IDX_LAST;
        end else begin
            if (w_load) begin
                r_valid <= w_any;
                r_idx   <= w_any ? w_win : '0;
                r_oh    <= w_any ? w_oh : '0;
            end
            if (w_hs && mode) begin
                r_ptr <= w_base;
            end
        end
    end

    assign grant_valid = r_valid;
    assign grant_idx   = r_idx;
    assign grant_oh    = r_oh;

endmodule

// File: tb/tb_prio_arb_rr.sv
// Bench for prio_arb_rr: N=8 and N=5 instances checked every cycle against a
// behavioural arbiter model, plus literal grant sequences.
module tb_prio_arb_rr;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] req8   = '0;
    logic       mode8  = 1'b0;
    logic       ready8 = 1'b0;
    logic [4:0] req5   = '0;
    logic       mode5  = 1'b0;
    logic       ready5 = 1'b0;

    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    int n_checks = 0;
    int n_fail   = 0;

    prio_arb_rr #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .grant_ready(ready8),
        .grant_valid(v8), .grant_idx(idx8), .grant_oh(oh8)
    );

    prio_arb_rr #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .grant_ready(ready5),
        .grant_valid(v5), .grant_idx(idx5), .grant_oh(oh5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the winner, or -1 if nothing requests.
    function automatic int search(input int n, input logic [63:0] r, input bit m, input int b);
        if (!m) begin
            for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j = (b - k + n) % n;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_next(input int n, input logic [63:0] r, input bit m, input bit rdy,
                              input bit v, input int idx, input int ptr,
                              output bit nv, output int ni, output int np);
        int b;
        int w;
        bit hs;
        nv = v;
        ni = idx;
        np = ptr;
        hs = v && rdy;
        if (v && !rdy) return;
        b  = hs ? ((idx == 0) ? n - 1 : idx - 1) : ptr;
        w  = search(n, r, m, b);
        nv = (w >= 0);
        ni = (w >= 0) ? w : 0;
        if (hs && m) np = b;
    endtask

    bit mv[2];
    int mi[2];
    int mp[2];
    bit nv8, nv5;
    int ni8, ni5, np8, np5;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv[0] <= 1'b0; mi[0] <= 0; mp[0] <= 7;
            mv[1] <= 1'b0; mi[1] <= 0; mp[1] <= 4;
        end else begin
            model_next(8, 64'(req8), mode8, ready8, mv[0], mi[0], mp[0], nv8, ni8, np8);
            model_next(5, 64'(req5), mode5, ready5, mv[1], mi[1], mp[1], nv5, ni5, np5);
            mv[0] <= nv8; mi[0] <= ni8; mp[0] <= np8;
            mv[1] <= nv5; mi[1] <= ni5; mp[1] <= np5;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m8_valid", 64'(v8), 64'(mv[0]));
            chk("m8_idx", 64'(idx8), 64'(mi[0]));
            chk("m8_oh", 64'(oh8), mv[0] ? (64'd1 << mi[0]) : 64'd0);
            chk("m5_valid", 64'(v5), 64'(mv[1]));
            chk("m5_idx", 64'(idx5), 64'(mi[1]));
            chk("m5_oh", 64'(oh5), mv[1] ? (64'd1 << mi[1]) : 64'd0);
            chk("n5_range", 64'(idx5 <= 3'd4), 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect8(input bit v, input int idx);
        chk("lit_valid", 64'(v8), 64'(v));
        chk("lit_idx", 64'(idx8), 64'(idx));
        chk("lit_oh", 64'(oh8), v ? (64'd1 << idx) : 64'd0);
    endtask

    int seq_rr[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int seq_70[4]  = '{0, 7, 0, 7};
    int seq_5a[4]  = '{4, 0, 4, 0};
    int seq_5b[6]  = '{4, 3, 2, 1, 0, 4};
    logic [7:0] tbl_req[12] = '{8'h00, 8'h24, 8'h24, 8'h24, 8'h24, 8'h01,
                                8'h01, 8'h00, 8'h40, 8'h41, 8'hC3, 8'hC3};
    bit tbl_mode[12]  = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    bit tbl_ready[12] = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1};

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        expect8(1'b0, 0);
        chk("rst5_valid", 64'(v5), 64'd0);
        chk("rst5_oh", 64'(oh5), 64'd0);
        #2 rst_n = 1'b1;

        // fixed priority
        mode8 = 1'b0; req8 = 8'b0010_0110; ready8 = 1'b1;
        step(); expect8(1'b1, 5);
        step(); expect8(1'b1, 5);
        step(); expect8(1'b1, 5);
        req8 = 8'b0000_0110;
        step(); expect8(1'b1, 2);

        // reset in the middle of a grant
        #2 rst_n = 1'b0; req8 = '0;
        #1 expect8(1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(); expect8(1'b0, 0);
        step(); expect8(1'b0, 0);

        // round-robin fairness
        mode8 = 1'b1; req8 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            step(); expect8(1'b1, seq_rr[i]);
        end
        req8 = 8'b1000_0001;
        for (int i = 0; i < 4; i++) begin
            step(); expect8(1'b1, seq_70[i]);
        end

        // backpressure hold
        req8 = 8'h08;
        step(); expect8(1'b1, 3);
        ready8 = 1'b0; req8 = 8'h80;
        for (int i = 0; i < 4; i++) begin
            step(); expect8(1'b1, 3);
        end
        ready8 = 1'b1;
        step(); expect8(1'b1, 7);

        // mode switch keeps the pointer
        req8 = 8'hFF;
        step(); expect8(1'b1, 6);
        step(); expect8(1'b1, 5);
        step(); expect8(1'b1, 4);
        step(); expect8(1'b1, 3);
        mode8 = 1'b0;
        step(); expect8(1'b1, 7);
        step(); expect8(1'b1, 7);
        step(); expect8(1'b1, 7);
        mode8 = 1'b1;
        step(); expect8(1'b1, 6);
        step(); expect8(1'b1, 5);

        // mixed vectors, checked by the model only
        for (int i = 0; i < 12; i++) begin
            req8 = tbl_req[i]; mode8 = tbl_mode[i]; ready8 = tbl_ready[i];
            step();
        end

        // non-power-of-two instance
        mode5 = 1'b1; req5 = 5'b10001; ready5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("n5_lit_idx", 64'(idx5), 64'(seq_5a[i]));
            chk("n5_lit_oh", 64'(oh5), 64'd1 << seq_5a[i]);
        end
        req5 = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("n5_wrap_idx", 64'(idx5), 64'(seq_5b[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
